rs485_rx: RTL and testbench
===========================

Name: rs485_rx

Overview:
- Receive half of the RS485 serial link. Frame format: start bit, 8 data bits LSB first, parity bit, stop bit.
- Runs on the same 16x-oversampled clock as the transmit side: 16 clocks per bit, and the stop bit may be as short as 8 clocks.
- Sits between the transceiver RO pin and the user logic. Delivers one byte per frame with a one-clock strobe plus parity and framing status.

Parameters:
- PARITY_MODE, 1'b0, seed XORed into the parity calculation. 0 = even parity, 1 = odd parity. Must match the transmitter.

Ports:
- clk  input  1  16x baud clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line from the transceiver; asynchronous to clk; idles high.
- dataout  output  8  last received byte; held until the next frame completes.
- rdsig  output  1  one-clock pulse when a frame completes.
- dataerror  output  1  parity mismatch on the last frame; held until the next frame completes.
- frameerror  output  1  stop bit sampled low on the last frame; held until the next frame completes.
- idle  output  1  high while a frame is being received, low when the line is free. Same polarity convention as the transmitter.

Behaviour:
- Reset: dataout=8'h00, rdsig=0, dataerror=0, frameerror=0, idle=0, state=IDLE, cnt=0, both synchronizer flops=1.
- Input path: rx goes through a 2-flop synchronizer (rx_s2 is the usable value), then a third flop rx_s3 for edge detection. Falling edge = rx_s3 & ~rx_s2.
- State IDLE:
  - cnt=0, idle=0.
  - On a falling edge: go to RECV, idle<=1, cnt<=1. The detect cycle counts as cnt 0.
  - Falling edges are only seen after rx has been high, so a line held low (break) never retriggers the receiver.
- State RECV: cnt increments by 1 every clock (8-bit counter, never wraps in normal operation). Sample points use rx_s2:
  - cnt==8, start-bit centre: if rx_s2==1, treat as a false start. Go to IDLE, idle<=0, no status change, no rdsig.
  - cnt==24+16*k, k=0..7: shift_reg[k] <= rx_s2.
  - cnt==152: par_bit <= rx_s2.
  - cnt==164: stop-bit sample, placed at the centre of the 8-clock-minimum stop bit. In the same edge:
    - dataout <= shift_reg
    - dataerror <= (^shift_reg ^ PARITY_MODE) != par_bit
    - frameerror <= ~rx_s2
    - rdsig <= 1
    - state <= IDLE, idle <= 0
- rdsig:
  - Deasserted on the following clock; exactly one cycle per accepted frame.
  - Asserted even when dataerror or frameerror is set. The consumer decides whether to drop the byte.
- Latency: the rdsig rising edge occurs 166-168 clocks after the rx falling edge (synchronizer plus sampling phase).
- Back-to-back frames: the receiver is back in IDLE before the stop bit ends. The transmitter's minimum 168-clock frame spacing is therefore received with no loss.
- Timing tolerance: the tx clock may be up to about ±2% off nominal; sample points stay inside the bit for the 10.5-bit span.
- Reset mid-frame: asynchronously return to the reset values. The partial byte is discarded and no rdsig is produced. The first falling edge after release starts a clean frame.
- Glitches shorter than 8 clocks that start a frame are rejected by the start check. Noise inside a frame is sampled once per bit; there is no majority vote.
- Shift register and par_bit are internal and not reset-critical, but are reset to 0 for determinism.

Test Plan:
- Even parity, byte 8'hA5, 16 clocks/bit, 8-clock stop -> dataout=8'hA5, rdsig high for exactly 1 clock at ~cnt 164, dataerror=0, frameerror=0, idle back to 0.
- Byte 8'h3C with the parity bit inverted -> dataout=8'h3C, rdsig pulses, dataerror=1, frameerror=0. A following correct frame 8'h01 -> dataerror returns to 0.
- Byte 8'hFF with the stop bit driven low -> dataout=8'hFF, rdsig pulses, frameerror=1. Line then held low: no new frame until rx returns high and falls again.
- rx low for 4 clocks, then high -> idle goes 1, then 0 at cnt 8. No rdsig; dataout and error flags unchanged.
- Three back-to-back frames 8'h00, 8'h55, 8'hC3 at 168-clock spacing -> three rdsig pulses, dataout sequence correct, no errors. Repeat with PARITY_MODE=1 and odd-parity stimulus -> same result.
- rst_n asserted at cnt 80 of a frame -> all outputs at reset values immediately. After release, the next frame 8'h7E is received correctly with a single rdsig.

Source files
------------

// File: rtl/rs485_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : rs485_rx_if
// Brief    : Serial line in, received byte and status out, for rs485_rx.
// Revision : 1.0
// ============================================================================
interface rs485_rx_if;
    logic       rx;
    logic [7:0] dataout;
    logic       rdsig;
    logic       dataerror;
    logic       frameerror;
    logic       idle;

    modport master (
        input  rx,
        output dataout, rdsig, dataerror, frameerror, idle
    );

    modport slave (
        output rx,
        input  dataout, rdsig, dataerror, frameerror, idle
    );
endinterface
`default_nettype wire

// File: rtl/rs485_rx.sv
`default_nettype none
// ============================================================================
// Module   : rs485_rx
// Brief    : 16x-oversampled RS485 receiver: start, 8 data LSB first, parity, stop.
// Revision : 1.0
// ============================================================================
module rs485_rx #(
    parameter logic PARITY_MODE = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    rs485_rx_if.master       bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    localparam logic [7:0] C_CNT_START = 8'd8;
    localparam logic [7:0] C_CNT_BIT0  = 8'd24;
    localparam logic [7:0] C_CNT_BIT7  = 8'd136;
    localparam logic [7:0] C_CNT_PAR   = 8'd152;
    localparam logic [7:0] C_CNT_STOP  = 8'd164;

    logic       r_rx_s1;
    logic       r_rx_s2;
    logic       r_rx_s3;
    logic [0:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_par;
    logic [7:0] r_dataout;
    logic       r_rdsig;
    logic       r_dataerror;
    logic       r_frameerror;
    logic       r_idle;

    logic       w_fall;
    logic       w_bit_pt;
    logic [2:0] w_bit_idx;

    // Reset high so a line idling high after reset produces no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= bus.rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign w_fall    = r_rx_s3 & ~r_rx_s2;
    // Data centres sit at 24 + 16*k, i.e. low nibble 8 with the high nibble giving k+1.
    assign w_bit_pt  = (r_cnt >= C_CNT_BIT0) && (r_cnt <= C_CNT_BIT7) && (r_cnt[3:0] == 4'd8);
    assign w_bit_idx = 3'(r_cnt[7:4] - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_shift      <= 8'd0;
            r_par        <= 1'b0;
            r_dataout    <= 8'd0;
            r_rdsig      <= 1'b0;
            r_dataerror  <= 1'b0;
            r_frameerror <= 1'b0;
            r_idle       <= 1'b0;
        end else begin
            r_rdsig <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_fall) begin
                        r_state <= S_RECV;
                        r_idle  <= 1'b1;
                        r_cnt   <= 8'd1;
                    end
                end
                S_RECV: begin
                    r_cnt <= r_cnt + 8'd1;
                    if ((r_cnt == C_CNT_START) && r_rx_s2) begin
                        r_state <= S_IDLE;
                        r_idle  <= 1'b0;
                        r_cnt   <= 8'd0;
                    end
                    if (w_bit_pt) begin
                        r_shift[w_bit_idx] <= r_rx_s2;
                    end
                    if (r_cnt == C_CNT_PAR) begin
                        r_par <= r_rx_s2;
                    end
                    // Stop-bit centre also closes the frame so back-to-back starts are caught.
                    if (r_cnt == C_CNT_STOP) begin
                        r_dataout    <= r_shift;
                        r_dataerror  <= ((^r_shift) ^ PARITY_MODE) != r_par;
                        r_frameerror <= ~r_rx_s2;
                        r_rdsig      <= 1'b1;
                        r_state      <= S_IDLE;
                        r_idle       <= 1'b0;
                        r_cnt        <= 8'd0;
                    end
                end
            endcase
        end
    end

    assign bus.dataout    = r_dataout;
    assign bus.rdsig      = r_rdsig;
    assign bus.dataerror  = r_dataerror;
    assign bus.frameerror = r_frameerror;
    assign bus.idle       = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_rs485_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs485_rx
// Brief    : Directed self-checking bench for rs485_rx (even and odd parity).
// Revision : 1.0
// ============================================================================
module tb_rs485_rx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   pulses0 = 0;
    int   pulses1 = 0;

    rs485_rx_if bus0();
    rs485_rx_if bus1();

    rs485_rx #(.PARITY_MODE(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    rs485_rx #(.PARITY_MODE(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus0.rdsig) pulses0 <= pulses0 + 1;
        if (bus1.rdsig) pulses1 <= pulses1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) bus1.rx = v;
        else     bus0.rx = v;
    endtask

    // Drives start, data and parity; returns at the start of the stop bit.
    task automatic drive_head(input bit sel, input logic [7:0] d, input logic par);
        set_rx(sel, 1'b0);
        tick(16);
        for (int k = 0; k < 8; k++) begin
            set_rx(sel, d[k]);
            tick(16);
        end
        set_rx(sel, par);
        tick(16);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                              input logic stop, input logic release_line, input string tag);
        int p0;
        p0 = sel ? pulses1 : pulses0;
        drive_head(sel, d, par);
        set_rx(sel, stop);
        tick(8);
        if (release_line) set_rx(sel, 1'b1);
        check({tag, "_pulses"}, 32'((sel ? pulses1 : pulses0) - p0), 32'd1);
    endtask

    task automatic check_out(input bit sel, input string tag, input logic [7:0] d,
                             input logic derr, input logic ferr);
        check({tag, "_dataout"},    32'(sel ? bus1.dataout    : bus0.dataout),    32'(d));
        check({tag, "_dataerror"},  32'(sel ? bus1.dataerror  : bus0.dataerror),  32'(derr));
        check({tag, "_frameerror"}, 32'(sel ? bus1.frameerror : bus0.frameerror), 32'(ferr));
        check({tag, "_idle"},       32'(sel ? bus1.idle       : bus0.idle),       32'd0);
    endtask

    initial begin
        int p;
        logic [10:0] fv;

        bus0.rx = 1'b1;
        bus1.rx = 1'b1;
        rst_n   = 1'b0;
        tick(3);
        check("rst_dataout",    32'(bus0.dataout),    32'h00);
        check("rst_rdsig",      32'(bus0.rdsig),      32'd0);
        check("rst_dataerror",  32'(bus0.dataerror),  32'd0);
        check("rst_frameerror", 32'(bus0.frameerror), 32'd0);
        check("rst_idle",       32'(bus0.idle),       32'd0);
        rst_n = 1'b1;
        tick(4);

        // 8'hA5, even parity bit 0, with cycle-exact rdsig checks
        p = pulses0;
        drive_head(1'b0, 8'hA5, 1'b0);
        check("a5_busy", 32'(bus0.idle), 32'd1);
        bus0.rx = 1'b1;
        tick(6);
        check("a5_rdsig_before", 32'(bus0.rdsig), 32'd0);
        tick(1);
        check("a5_rdsig", 32'(bus0.rdsig), 32'd1);
        check_out(1'b0, "a5", 8'hA5, 1'b0, 1'b0);
        tick(1);
        check("a5_rdsig_after", 32'(bus0.rdsig), 32'd0);
        check("a5_pulses", 32'(pulses0 - p), 32'd1);

        // 8'h3C with inverted parity, then a clean 8'h01
        send_frame(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, "3c");
        check_out(1'b0, "3c", 8'h3C, 1'b1, 1'b0);
        send_frame(1'b0, 8'h01, 1'b1, 1'b1, 1'b1, "01");
        check_out(1'b0, "01", 8'h01, 1'b0, 1'b0);

        // 8'hFF with stop low, line then held low as a break
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, "ff");
        check_out(1'b0, "ff", 8'hFF, 1'b0, 1'b1);
        p = pulses0;
        tick(200);
        check("break_idle",   32'(bus0.idle),   32'd0);
        check("break_pulses", 32'(pulses0 - p), 32'd0);
        bus0.rx = 1'b1;
        tick(20);
        send_frame(1'b0, 8'h12, 1'b0, 1'b1, 1'b1, "12");
        check_out(1'b0, "12", 8'h12, 1'b0, 1'b0);

        // 4-clock glitch: false start rejected at the start-bit centre
        p = pulses0;
        bus0.rx = 1'b0;
        tick(4);
        bus0.rx = 1'b1;
        check("glitch_busy", 32'(bus0.idle), 32'd1);
        tick(6);
        check("glitch_busy_late", 32'(bus0.idle), 32'd1);
        tick(1);
        check("glitch_released", 32'(bus0.idle), 32'd0);
        tick(200);
        check("glitch_pulses", 32'(pulses0 - p), 32'd0);
        check_out(1'b0, "glitch", 8'h12, 1'b0, 1'b0);

        // Back-to-back frames at 168-clock spacing, even then odd parity
        send_frame(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "b2b_00");
        check_out(1'b0, "b2b_00", 8'h00, 1'b0, 1'b0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b1, 1'b1, "b2b_55");
        check_out(1'b0, "b2b_55", 8'h55, 1'b0, 1'b0);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, "b2b_c3");
        check_out(1'b0, "b2b_c3", 8'hC3, 1'b0, 1'b0);
        send_frame(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, "odd_00");
        check_out(1'b1, "odd_00", 8'h00, 1'b0, 1'b0);
        send_frame(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, "odd_55");
        check_out(1'b1, "odd_55", 8'h55, 1'b0, 1'b0);
        send_frame(1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, "odd_c3");
        check_out(1'b1, "odd_c3", 8'hC3, 1'b0, 1'b0);
        tick(10);

        // Reset asserted at cnt 80 of a frame carrying 8'hE7 (parity 0)
        p  = pulses0;
        fv = {1'b1, 1'b0, 8'hE7, 1'b0};
        for (int i = 0; i < 82; i++) begin
            bus0.rx = fv[i / 16];
            @(negedge clk);
        end
        check("midrst_busy", 32'(bus0.idle), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_dataout", 32'(bus0.dataout), 32'h00);
        check("midrst_idle",    32'(bus0.idle),    32'd0);
        check("midrst_rdsig",   32'(bus0.rdsig),   32'd0);
        bus0.rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        send_frame(1'b0, 8'h7E, 1'b0, 1'b1, 1'b1, "7e");
        check_out(1'b0, "7e", 8'h7E, 1'b0, 1'b0);
        check("midrst_total_pulses", 32'(pulses0 - p), 32'd1);
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
